alu_rr_sequencer: RTL and testbench

- Shares one WIDTH-bit, 4-function ALU between two requesters using round-robin arbitration.
- Each requester presents an opcode and two operands on a valid/ready handshake.
- The block latches the winning request, computes the result with the same semantics as the team's ALU, registers it, and returns it on a single shared response channel tagged with the requester id.
- It sits between the requester front-ends and the ALU datapath. It is the only path to the ALU.

---
 rtl/alu_rr_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// Round-robin front end sharing one 4-function ALU between two requesters.
// Accepts a request in IDLE, computes in EXEC, and holds the tagged response in RESP.
module alu_rr_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [1:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a request transfers on req_valid_i[k] && req_ready_o[k] at a rising
  // edge; a response transfers on rsp_valid_o && rsp_ready_i at a rising edge.
  // Neither valid may depend on the corresponding ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic             grant;
  logic             req_pending;
  logic [WIDTH:0]   alu_res;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    req_pending = |req_valid_i;
    if (req_valid_i == 2'b11) begin
      grant = ~last_grant_q;
    end else begin
      grant = req_valid_i[1];
    end
  end

  assign req_ready_o = (state_q == IDLE && req_pending) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // Subtraction wraps modulo 2^(WIDTH+1), so the top bit is the borrow.
  always_comb begin
    alu_res = '0;
    case (op_q)
      2'd0:    alu_res = {1'b0, a_q} + {1'b0, b_q};
      2'd1:    alu_res = {1'b0, a_q} - {1'b0, b_q};
      2'd2:    alu_res = {1'b0, a_q & b_q};
      default: alu_res = {1'b0, a_q | b_q};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    case (state_q)
      IDLE: begin
        if (req_pending) begin
          op_d         = grant ? req1_op_i : req0_op_i;
          a_d          = grant ? req1_a_i  : req0_a_i;
          b_d          = grant ? req1_b_i  : req0_b_i;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_res[WIDTH-1:0];
        rsp_carry_d  = alu_res[WIDTH];
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // Data registers are left as-is after the handshake; only valid drops.
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_carry_o  = rsp_carry_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: latency, round-robin order, backpressure,
// mid-operation reset and ALU corner values, all with hand-computed expectations.
module tb_alu_rr_sequencer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  alu_rr_sequencer #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req0_op_i    (req0_op),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req1_op_i    (req1_op),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_carry_o  (rsp_carry),
    .dbg_state_o  (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a response, checks it, then lets the handshake edge pass.
  task automatic wait_rsp(input string tag, input logic exp_id,
                          input logic [WIDTH-1:0] exp_res, input logic exp_carry);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_id"}, rsp_id, exp_id);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_carry"}, rsp_carry, exp_carry);
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req0_op = 2'd0; req0_a = '0; req0_b = '0;
    req1_op = 2'd0; req1_a = '0; req1_b = '0;
    #2;
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_result", rsp_result, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    // Single request from requester 0: accept, EXEC, then RESP two edges later.
    req_valid = 2'b01; req0_op = 2'd0; req0_a = 8'h0F; req0_b = 8'h01;
    #1;
    chk("t1_ready_idle", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t1_state_exec", dbg_state, 2'd1);
    chk("t1_ready_exec", req_ready, 2'b00);
    chk("t1_valid_exec", rsp_valid, 1'b0);
    tick();
    chk("t1_valid_resp", rsp_valid, 1'b1);
    wait_rsp("t1", 1'b0, 8'h10, 1'b0);
    chk("t1_valid_after", rsp_valid, 1'b0);

    // Requester 1 alone, served back-to-back with AND then OR.
    req_valid = 2'b10; req1_op = 2'd2; req1_a = 8'hF0; req1_b = 8'h3C;
    #1;
    chk("t3_ready_first", req_ready, 2'b10);
    wait_rsp("t3_and", 1'b1, 8'h30, 1'b0);
    req1_op = 2'd3;
    #1;
    chk("t3_ready_again", req_ready, 2'b10);
    wait_rsp("t3_or", 1'b1, 8'hFC, 1'b0);
    req_valid = 2'b00;

    // Both continuously valid: 0, 1, 0 ordering, sub borrow and add wrap.
    req0_op = 2'd1; req0_a = 8'h05; req0_b = 8'h07;
    req1_op = 2'd0; req1_a = 8'hFF; req1_b = 8'h01;
    req_valid = 2'b11;
    #1;
    chk("t2_ready_tie", req_ready, 2'b01);
    wait_rsp("t2_a", 1'b0, 8'hFE, 1'b1);
    wait_rsp("t2_b", 1'b1, 8'h00, 1'b1);
    wait_rsp("t2_c", 1'b0, 8'hFE, 1'b1);
    req_valid = 2'b00;

    // Backpressure: both pending, requester 1 wins the tie, response held 5 cycles.
    req1_op = 2'd3; req1_a = 8'h0F; req1_b = 8'hA0;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    #1;
    chk("t4_ready_tie", req_ready, 2'b10);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", rsp_valid, 1'b1);
      chk("t4_hold_result", rsp_result, 8'hAF);
      chk("t4_hold_id", rsp_id, 1'b1);
      chk("t4_hold_ready", req_ready, 2'b00);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_done_valid", rsp_valid, 1'b0);
    chk("t4_done_result", rsp_result, 8'hAF);
    chk("t4_next_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();

    // Reset while in EXEC: outputs clear at once, no stale response afterwards.
    req0_op = 2'd0; req0_a = 8'h01; req0_b = 8'h01;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("t5_state_exec", dbg_state, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", rsp_valid, 1'b0);
    chk("t5_rst_result", rsp_result, 8'h00);
    chk("t5_rst_id", rsp_id, 1'b0);
    chk("t5_rst_state", dbg_state, 2'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_stale", rsp_valid, 1'b0);
    end

    // First tie after reset goes to requester 0; sub with equal operands.
    req0_op = 2'd1; req0_a = 8'h80; req0_b = 8'h80;
    req1_op = 2'd0; req1_a = 8'h11; req1_b = 8'h22;
    req_valid = 2'b11;
    #1;
    chk("t6_ready_tie", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    wait_rsp("t6_sub_eq", 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
